// File: rtl/axis_switch_pkg.sv
// Shared definitions for the AXI-Stream switch family (1-to-N and N-to-1).
// Holds the arbitration FSM state encoding and the select-width helper.
package axis_switch_pkg;

    typedef enum logic [0:0] {
        IDLE        = 1'b0,
        TRANSACTION = 1'b1
    } axis_sw_state_e;

    // Width of a slave index; never less than one bit so single-slave builds still elaborate.
    function automatic int sel_bits(input int n);
        int b;
        b = $clog2(n);
        if (b < 1) begin
            return 1;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational round-robin arbiter: finds the first requester at or above
// ptr, wrapping from N-1 back to 0. Reused by the stream muxes.
module axis_rr_arbiter
    import axis_switch_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = sel_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          grant_valid,
    output logic [PW-1:0] grant_idx
);

    // Walk offsets from the far end down to 0 so the closest requester to ptr is written last and wins.
    always_comb begin
        int            cand_s;
        logic [PW-1:0] cand_idx_s;
        cand_s      = 0;
        cand_idx_s  = {PW{1'b0}};
        grant_valid = 1'b0;
        grant_idx   = {PW{1'b0}};
        for (int off = N - 1; off >= 0; off--) begin
            cand_s      = (int'(ptr) + off) % N;
            cand_idx_s  = PW'(cand_s);
            grant_valid = grant_valid | req[cand_idx_s];
            grant_idx   = req[cand_idx_s] ? cand_idx_s : grant_idx;
        end
    end

endmodule

// File: rtl/axis_switch_single_master.sv
// N-slave to 1-master AXI-Stream switch with round-robin arbitration.
// A grant is held for one beat (HAS_LAST=0) or until the tlast beat (HAS_LAST=1).
// Every grant spends one IDLE bubble cycle before the first beat is forwarded.
// Optional macro AXIS_SWITCH_SINGLE_MASTER_OUTREG_EN adds a 2-entry skid slice
// on the master side so all m_* outputs come straight from flops.
module axis_switch_single_master
    import axis_switch_pkg::*;
#(
    parameter int NSLAVES    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int HAS_DEST   = 0,
    parameter int HAS_ID     = 0,
    parameter int HAS_LAST   = 0,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NSLAVES-1:0]            s_valid,
    output logic [NSLAVES-1:0]            s_ready,
    input  logic [NSLAVES*DATA_WIDTH-1:0] s_data,
    input  logic [NSLAVES*DEST_WIDTH-1:0] s_dest,
    input  logic [NSLAVES*ID_WIDTH-1:0]   s_id,
    input  logic [NSLAVES-1:0]            s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [DEST_WIDTH-1:0]         m_dest,
    output logic [ID_WIDTH-1:0]           m_id,
    output logic                          m_last
);

    localparam int SW = sel_bits(NSLAVES);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic [ID_WIDTH-1:0]   id;
        logic                  last;
    } beat_t;

    generate
        if (NSLAVES == 1) begin : g_passthrough
            // A single source needs no arbitration: wire straight through.
            assign m_valid = s_valid[0];
            assign s_ready = m_ready;
            assign m_data  = s_data;
            assign m_dest  = (HAS_DEST != 0) ? s_dest : {DEST_WIDTH{1'b0}};
            assign m_id    = (HAS_ID != 0) ? s_id : {ID_WIDTH{1'b0}};
            assign m_last  = (HAS_LAST != 0) ? s_last[0] : 1'b0;
        end else begin : g_switch
            axis_sw_state_e     state_q, state_d;
            logic [SW-1:0]      sel_q, sel_d;
            logic [SW-1:0]      rr_q, rr_d;
            logic               grant_valid_s;
            logic [SW-1:0]      grant_idx_s;
            logic               slv_valid_s;
            logic               take_s;
            logic               push_s;
            logic               exit_s;
            logic [NSLAVES-1:0] s_ready_s;
            beat_t              slv_beat_s;

            axis_rr_arbiter #(
                .N  (NSLAVES),
                .PW (SW)
            ) u_arb (
                .req         (s_valid),
                .ptr         (rr_q),
                .grant_valid (grant_valid_s),
                .grant_idx   (grant_idx_s)
            );

            // Select the granted slave's payload, zeroing sideband fields that are disabled.
            always_comb begin
                slv_beat_s.data = s_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
                slv_beat_s.dest = (HAS_DEST != 0) ? s_dest[int'(sel_q)*DEST_WIDTH +: DEST_WIDTH]
                                                  : {DEST_WIDTH{1'b0}};
                slv_beat_s.id   = (HAS_ID != 0) ? s_id[int'(sel_q)*ID_WIDTH +: ID_WIDTH]
                                                : {ID_WIDTH{1'b0}};
                slv_beat_s.last = (HAS_LAST != 0) ? s_last[sel_q] : 1'b0;
            end

            assign slv_valid_s = s_valid[sel_q];
            // Slave-side handshake of the granted stream; packet exit is judged here.
            assign push_s = (state_q == TRANSACTION) && slv_valid_s && take_s;
            assign exit_s = push_s && ((HAS_LAST == 0) || s_last[sel_q]);

            // Arbitration FSM: grant in IDLE, hold the grant until the exiting handshake.
            always_comb begin
                state_d = state_q;
                sel_d   = sel_q;
                rr_d    = rr_q;
                case (state_q)
                    IDLE: begin
                        if (grant_valid_s) begin
                            sel_d   = grant_idx_s;
                            state_d = TRANSACTION;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    TRANSACTION: begin
                        if (exit_s) begin
                            rr_d    = (sel_q == SW'(NSLAVES - 1)) ? {SW{1'b0}} : sel_q + SW'(1);
                            state_d = IDLE;
                        end else begin
                            state_d = TRANSACTION;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end

            // Only the granted slave sees ready, and only while a transaction is open.
            always_comb begin
                s_ready_s = {NSLAVES{1'b0}};
                for (int i = 0; i < NSLAVES; i++) begin
                    s_ready_s[i] = (state_q == TRANSACTION) && (sel_q == SW'(i)) && take_s;
                end
            end
            assign s_ready = s_ready_s;

            // Arbitration state registers with synchronous active-low reset.
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    state_q <= IDLE;
                    sel_q   <= {SW{1'b0}};
                    rr_q    <= {SW{1'b0}};
                end else begin
                    state_q <= state_d;
                    sel_q   <= sel_d;
                    rr_q    <= rr_d;
                end
            end

`ifdef AXIS_SWITCH_SINGLE_MASTER_OUTREG_EN
            // Two-entry skid slice; slot 0 is always the head presented on the master port.
            logic  v0_q, v0_d, v1_q, v1_d;
            beat_t b0_q, b0_d, b1_q, b1_d;
            logic  pop_s;

            // Accept from the slave whenever slot 1 is free; this keeps 1 beat/cycle.
            assign take_s = ~v1_q;
            assign pop_s  = v0_q & m_ready;

            // Shift the slice on a master pop, then drop the incoming beat into the lowest free slot.
            always_comb begin
                v0_d = v0_q;
                v1_d = v1_q;
                b0_d = b0_q;
                b1_d = b1_q;
                if (pop_s) begin
                    v0_d = v1_q;
                    b0_d = b1_q;
                    v1_d = 1'b0;
                end else begin
                    v1_d = v1_q;
                end
                if (push_s) begin
                    if (!v0_d) begin
                        v0_d = 1'b1;
                        b0_d = slv_beat_s;
                    end else begin
                        v1_d = 1'b1;
                        b1_d = slv_beat_s;
                    end
                end else begin
                    b1_d = b1_d;
                end
            end

            // Slice registers; reset empties the slice.
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    v0_q <= 1'b0;
                    v1_q <= 1'b0;
                    b0_q <= '0;
                    b1_q <= '0;
                end else begin
                    v0_q <= v0_d;
                    v1_q <= v1_d;
                    b0_q <= b0_d;
                    b1_q <= b1_d;
                end
            end

            assign m_valid = v0_q;
            assign m_data  = b0_q.data;
            assign m_dest  = b0_q.dest;
            assign m_id    = b0_q.id;
            assign m_last  = b0_q.last;
`else
            // Combinational master path: m_ready reaches s_ready in the same cycle.
            assign take_s  = m_ready;
            assign m_valid = (state_q == TRANSACTION) && slv_valid_s;
            assign m_data  = slv_beat_s.data;
            assign m_dest  = slv_beat_s.dest;
            assign m_id    = slv_beat_s.id;
            assign m_last  = slv_beat_s.last;
`endif
        end
    endgenerate

endmodule

// File: doc/axis_switch_single_master.md
Name: axis_switch_single_master

Overview:
N-slave-to-1-master AXI-Stream switch (mux), the counterpart of the 1-to-N dest-routed demux switch. Merges NSLAVES stream sources into one master stream using round-robin arbitration. A grant is locked for one beat (HAS_LAST=0) or for a full packet up to TLAST (HAS_LAST=1). Sits in front of shared consumers, e.g. the manager's command-in path fed by several accelerators.

Parameters:
NSLAVES, 2, number of slave (input) streams; >=1
DATA_WIDTH, 64, tdata width per stream
HAS_DEST, 0, 1 = tdest carried from the granted slave to the master
HAS_ID, 0, 1 = tid carried from the granted slave to the master
HAS_LAST, 0, 1 = grant held until the tlast beat; 0 = grant released after each beat
ID_WIDTH, 1, tid width per stream
DEST_WIDTH, 1, tdest width per stream

Ports:
aclk  in  1  clock; all logic on the rising edge
aresetn  in  1  synchronous, active-low reset
s_valid  in  NSLAVES  per-slave tvalid
s_ready  out  NSLAVES  per-slave tready
s_data  in  NSLAVES*DATA_WIDTH  slave i occupies [i*DATA_WIDTH +: DATA_WIDTH]
s_dest  in  NSLAVES*DEST_WIDTH  per-slave tdest, packed like s_data
s_id  in  NSLAVES*ID_WIDTH  per-slave tid, packed like s_data
s_last  in  NSLAVES  per-slave tlast
m_valid  out  1  master tvalid
m_ready  in  1  master tready
m_data  out  DATA_WIDTH  master tdata
m_dest  out  DEST_WIDTH  master tdest; 0 when HAS_DEST=0
m_id  out  ID_WIDTH  master tid; 0 when HAS_ID=0
m_last  out  1  master tlast; 0 when HAS_LAST=0

Behaviour:
- Clock and reset: one clock, aclk. aresetn is synchronous and active-low. Reset is sampled on the aclk edge and overrides every other next-state assignment.
- Reset values: state=IDLE, rr_ptr=0, m_valid=0, s_ready=all 0.
- NSLAVES==1: pure combinational passthrough. No state machine and no arbitration cycle.
- States: IDLE, TRANSACTION.
- IDLE:
  - m_valid=0 and s_ready=0.
  - If any s_valid bit is set, grant the first set bit found searching from index rr_ptr upward, wrapping from NSLAVES-1 to 0.
  - On grant: sel_slave<=winner and go to TRANSACTION.
  - A grant always costs one bubble cycle; first-beat latency is 1 cycle from s_valid to m_valid.
- TRANSACTION:
  - m_valid=s_valid[sel_slave].
  - s_ready[sel_slave]=m_ready; all other s_ready bits are 0.
  - m_data, m_dest, m_id and m_last are muxed from sel_slave.
- Exit from TRANSACTION:
  - HAS_LAST=0: exit on the first beat handshake (s_valid[sel] && m_ready).
  - HAS_LAST=1: exit on a handshake with s_last[sel]=1.
  - On exit: rr_ptr<=(sel_slave+1) mod NSLAVES, state<=IDLE.
- Grant validity: sel_slave is meaningful only in TRANSACTION. A granted slave that drops s_valid mid-packet keeps the grant, because AXIS forbids a valid drop before handshake. Gaps between beats are allowed and do not release the grant.
- Fairness: with all slaves requesting continuously, grants rotate 0,1,…,N-1,0. No slave waits more than N-1 packets.
- Width rules: sel_slave and rr_ptr are $clog2(NSLAVES) bits. The wrap compare uses NSLAVES, not a power of two.
- Reset mid-packet: on the reset edge the state returns to IDLE and outputs go to their reset values. The partial packet is truncated; upstream and downstream must be reset together.
- Protocol invariant: no output changes while m_valid=1 && m_ready=0.

Optional Feature:
Macro AXIS_SWITCH_SINGLE_MASTER_OUTREG_EN.
- Defined: a 2-entry skid register slice sits on the master side, so m_* are driven from flops. Added latency is +1 cycle, giving 2 cycles from s_valid to first m_valid. Full throughput (1 beat/cycle) is kept. s_ready[sel] is taken from the slice's not-full status, not from m_ready. Packet exit is evaluated on the slave-side handshake. On reset the slice empties.
- Undefined: the combinational master path described above. m_ready reaches s_ready in zero cycles.

Decomposition:
- Package axis_switch_pkg:
  - state enum {IDLE, TRANSACTION}
  - function sel_bits(n) returning max(1,$clog2(n))
  - shared with the 1-to-N switch.
- Sub-module axis_rr_arbiter: inputs req[NSLAVES] and ptr; outputs grant_valid and grant_idx. Purely combinational, reused by other muxes.
- The optional slice is inline in this block.

Test Plan:
- Reset, then s_valid=2'b01 with data 0xA: IDLE for 1 cycle, then m_valid=1, m_data=0xA, s_ready=2'b01. After the handshake, rr_ptr=1.
- NSLAVES=3, HAS_LAST=0, all valid continuously, m_ready=1: grant order 0,1,2,0. Each beat is separated by one idle cycle.
- HAS_LAST=1: slave1 sends a 4-beat packet while slave0 asserts valid at beat 2. Slave0 is not granted until after slave1's tlast beat; m_last=1 only on beat 4.
- m_ready held at 0 for 5 cycles mid-packet: m_data and m_valid stay stable, s_ready[sel]=0, no beat lost or duplicated.
- aresetn low for 1 cycle at beat 2 of 4: next cycle m_valid=0, s_ready=0, state IDLE, rr_ptr=0.
- AXIS_SWITCH_SINGLE_MASTER_OUTREG_EN: back-to-back 8-beat packet with m_ready toggling 1010…: all 8 beats delivered in order. First m_valid arrives 2 cycles after s_valid.
